bf_radix2_pipe: RTL and testbench

Pipelined, parametrised radix-2 DIF butterfly for the R2MDC FFT datapath: Y0 = A + B, Y1 = (A − B)·W, complex signed fixed-point. It generalises the combinational butterfly with configurable data, twiddle and fraction widths, optional per-stage 1/2 scaling, round-half-up, saturation with an overflow flag, and a 3-stage valid/ready pipeline. It sits between the delay-commutator of stage s and the input of stage s+1.

---
 rtl/bf_radix2_pipe.sv | 161 ++++++++++++++++
 tb/tb_bf_radix2_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bf_radix2_pipe.sv
// Pipelined radix-2 DIF butterfly: Y0 = A + B, Y1 = (A - B) * W.
// Three register stages (sum/diff, products, combine+round+saturate) that
// shift together under a single advance enable; the last stage is the output.
module bf_radix2_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int FRAC_W = 8,
  parameter int SCALE  = 0,
  parameter int ROUND  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a_re,
  input  logic signed [DATA_W-1:0] a_im,
  input  logic signed [DATA_W-1:0] b_re,
  input  logic signed [DATA_W-1:0] b_im,
  input  logic signed [TW_W-1:0]   w_re,
  input  logic signed [TW_W-1:0]   w_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] y0_re,
  output logic signed [DATA_W-1:0] y0_im,
  output logic signed [DATA_W-1:0] y1_re,
  output logic signed [DATA_W-1:0] y1_im,
  output logic                     sat,
  output logic                     sat_sticky,
  input  logic                     sat_clr
);

  localparam int SW  = DATA_W + 1;          // sum/diff width, lossless
  localparam int PW  = SW + TW_W;           // single product width
  localparam int WW  = DATA_W + TW_W + 3;   // combine width plus rounding headroom
  localparam int SH1 = FRAC_W + SCALE;
  localparam int SH0 = SCALE;

  localparam logic signed [WW-1:0] MAXV = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  // Arithmetic right shift, optionally rounding half up.
  function automatic logic signed [WW-1:0] shr_rnd(input logic signed [WW-1:0] v, input int sh);
    logic signed [WW-1:0] half;
    half = '0;
    if (ROUND != 0 && sh > 0) half = WW'(1) << (sh - 1);
    return (v + half) >>> sh;
  endfunction

  function automatic logic ovf(input logic signed [WW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [DATA_W-1:0] clip(input logic signed [WW-1:0] v);
    if (v > MAXV)      return MAXV[DATA_W-1:0];
    else if (v < MINV) return MINV[DATA_W-1:0];
    else               return v[DATA_W-1:0];
  endfunction

  logic advance;
  logic vld_p1_q, vld_p2_q, vld_p3_q;

  logic signed [SW-1:0]   sum_re_p1_q, sum_im_p1_q, diff_re_p1_q, diff_im_p1_q;
  logic signed [TW_W-1:0] w_re_p1_q, w_im_p1_q;
  logic signed [SW-1:0]   sum_re_p2_q, sum_im_p2_q;
  logic signed [PW-1:0]   rr_p2_q, ii_p2_q, ri_p2_q, ir_p2_q;

  logic signed [WW-1:0]     p_re, p_im, y0r_w, y0i_w, y1r_w, y1i_w;
  logic signed [DATA_W-1:0] y0_re_d, y0_im_d, y1_re_d, y1_im_d;
  logic signed [DATA_W-1:0] y0_re_q, y0_im_q, y1_re_q, y1_im_q;
  logic                     sat_d, sat_q, sat_sticky_d, sat_sticky_q;

  assign advance  = !vld_p3_q || out_ready;
  assign in_ready = advance;

  // Valid bits of all three stages shift together on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else if (advance) begin
      vld_p1_q <= in_valid;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
    end
  end

  // Stage 1 and 2 datapath registers: sum/diff, then the four partial products.
  always_ff @(posedge clk) begin
    if (advance) begin
      sum_re_p1_q  <= SW'(a_re) + SW'(b_re);
      sum_im_p1_q  <= SW'(a_im) + SW'(b_im);
      diff_re_p1_q <= SW'(a_re) - SW'(b_re);
      diff_im_p1_q <= SW'(a_im) - SW'(b_im);
      w_re_p1_q    <= w_re;
      w_im_p1_q    <= w_im;
      sum_re_p2_q  <= sum_re_p1_q;
      sum_im_p2_q  <= sum_im_p1_q;
      rr_p2_q      <= PW'(diff_re_p1_q) * PW'(w_re_p1_q);
      ii_p2_q      <= PW'(diff_im_p1_q) * PW'(w_im_p1_q);
      ri_p2_q      <= PW'(diff_re_p1_q) * PW'(w_im_p1_q);
      ir_p2_q      <= PW'(diff_im_p1_q) * PW'(w_re_p1_q);
    end
  end

  // Stage 3 combine, scale, round and saturate.
  always_comb begin
    p_re    = WW'(rr_p2_q) - WW'(ii_p2_q);
    p_im    = WW'(ri_p2_q) + WW'(ir_p2_q);
    y1r_w   = shr_rnd(p_re, SH1);
    y1i_w   = shr_rnd(p_im, SH1);
    y0r_w   = shr_rnd(WW'(sum_re_p2_q), SH0);
    y0i_w   = shr_rnd(WW'(sum_im_p2_q), SH0);
    y0_re_d = clip(y0r_w);
    y0_im_d = clip(y0i_w);
    y1_re_d = clip(y1r_w);
    y1_im_d = clip(y1i_w);
    sat_d   = ovf(y0r_w) | ovf(y0i_w) | ovf(y1r_w) | ovf(y1i_w);
  end

  // Output register: loads only real beats; bubbles keep data and clear sat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y0_re_q <= '0;
      y0_im_q <= '0;
      y1_re_q <= '0;
      y1_im_q <= '0;
      sat_q   <= 1'b0;
    end else if (advance) begin
      sat_q <= vld_p2_q & sat_d;
      if (vld_p2_q) begin
        y0_re_q <= y0_re_d;
        y0_im_q <= y0_im_d;
        y1_re_q <= y1_re_d;
        y1_im_q <= y1_im_d;
      end
    end
  end

  // Sticky flag: clear has priority over a set from a transferred beat.
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    if (sat_clr)                               sat_sticky_d = 1'b0;
    else if (vld_p3_q && out_ready && sat_q)   sat_sticky_d = 1'b1;
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_sticky_q <= 1'b0;
    else        sat_sticky_q <= sat_sticky_d;
  end

  assign out_valid  = vld_p3_q;
  assign y0_re      = y0_re_q;
  assign y0_im      = y0_im_q;
  assign y1_re      = y1_re_q;
  assign y1_im      = y1_im_q;
  assign sat        = sat_q;
  assign sat_sticky = sat_sticky_q;

endmodule

// File: tb/tb_bf_radix2_pipe.sv
// Directed bench for bf_radix2_pipe: three instances sharing the input side
// (default, ROUND=0, SCALE=1) so rounding and scaling variants see identical beats.
module tb_bf_radix2_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, out_ready, sat_clr;
  logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;

  logic u_in_ready, u_out_valid, u_sat, u_sat_sticky;
  logic signed [15:0] u_y0_re, u_y0_im, u_y1_re, u_y1_im;
  logic r_in_ready, r_out_valid, r_sat, r_sat_sticky;
  logic signed [15:0] r_y0_re, r_y0_im, r_y1_re, r_y1_im;
  logic s_in_ready, s_out_valid, s_sat, s_sat_sticky;
  logic signed [15:0] s_y0_re, s_y0_im, s_y1_re, s_y1_im;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bf_radix2_pipe #(.DATA_W(16), .TW_W(16), .FRAC_W(8), .SCALE(0), .ROUND(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(u_out_valid), .out_ready(out_ready),
    .y0_re(u_y0_re), .y0_im(u_y0_im), .y1_re(u_y1_re), .y1_im(u_y1_im),
    .sat(u_sat), .sat_sticky(u_sat_sticky), .sat_clr(sat_clr));

  bf_radix2_pipe #(.DATA_W(16), .TW_W(16), .FRAC_W(8), .SCALE(0), .ROUND(0)) r_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r_in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(r_out_valid), .out_ready(out_ready),
    .y0_re(r_y0_re), .y0_im(r_y0_im), .y1_re(r_y1_re), .y1_im(r_y1_im),
    .sat(r_sat), .sat_sticky(r_sat_sticky), .sat_clr(sat_clr));

  bf_radix2_pipe #(.DATA_W(16), .TW_W(16), .FRAC_W(8), .SCALE(1), .ROUND(1)) s_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .y0_re(s_y0_re), .y0_im(s_y0_im), .y1_re(s_y1_re), .y1_im(s_y1_im),
    .sat(s_sat), .sat_sticky(s_sat_sticky), .sat_clr(sat_clr));

  // Present one beat, then wait (bounded) until it reaches the output.
  // lat = number of clock edges after the accepting edge.
  task automatic drive_beat(input int ar, input int ai, input int br, input int bi,
                            input int wr, input int wi, input bit ordy, output int lat);
    @(negedge clk);
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    w_re = 16'(wr); w_im = 16'(wi);
    out_ready = ordy;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!u_out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (u_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", u_out_valid); end
    n_cmp++; if (u_y0_re !== 16'sd0 || u_y0_im !== 16'sd0 || u_y1_re !== 16'sd0 || u_y1_im !== 16'sd0) begin
      n_err++; $display("FAIL rst_outputs got %0d %0d %0d %0d want 0 0 0 0", u_y0_re, u_y0_im, u_y1_re, u_y1_im); end
    n_cmp++; if (u_sat !== 1'b0 || u_sat_sticky !== 1'b0) begin n_err++; $display("FAIL rst_sat got %b/%b want 0/0", u_sat, u_sat_sticky); end
    @(negedge clk); rst_n = 1'b1;
    #1;
    n_cmp++; if (u_in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", u_in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    drive_beat(256, 0, 128, 0, 256, 0, 1'b1, lat);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL t1_latency got %0d want 2", lat); end
    n_cmp++; if (u_y0_re !== 16'sd384 || u_y0_im !== 16'sd0) begin n_err++; $display("FAIL t1_y0 got (%0d,%0d) want (384,0)", u_y0_re, u_y0_im); end
    n_cmp++; if (u_y1_re !== 16'sd128 || u_y1_im !== 16'sd0) begin n_err++; $display("FAIL t1_y1 got (%0d,%0d) want (128,0)", u_y1_re, u_y1_im); end
    n_cmp++; if (u_sat !== 1'b0) begin n_err++; $display("FAIL t1_sat got %b want 0", u_sat); end
    n_cmp++; if (s_y0_re !== 16'sd192 || s_y1_re !== 16'sd64) begin n_err++; $display("FAIL t1_scaled got y0=%0d y1=%0d want 192 64", s_y0_re, s_y1_re); end
    @(posedge clk); #1;
    n_cmp++; if (u_out_valid !== 1'b0) begin n_err++; $display("FAIL t1_single got out_valid=%b want 0", u_out_valid); end

    drive_beat(256, 0, 128, 0, 0, -256, 1'b1, lat);
    n_cmp++; if (u_y1_re !== 16'sd0 || u_y1_im !== -16'sd128) begin n_err++; $display("FAIL t2_y1 got (%0d,%0d) want (0,-128)", u_y1_re, u_y1_im); end

    drive_beat(256, 0, 0, 0, 181, -181, 1'b1, lat);
    n_cmp++; if (u_y1_re !== 16'sd181 || u_y1_im !== -16'sd181) begin n_err++; $display("FAIL t3_y1 got (%0d,%0d) want (181,-181)", u_y1_re, u_y1_im); end
    n_cmp++; if (u_y0_re !== 16'sd256 || u_y0_im !== 16'sd0) begin n_err++; $display("FAIL t3_y0 got (%0d,%0d) want (256,0)", u_y0_re, u_y0_im); end
  endtask

  task automatic test_rounding();
    int lat;
    drive_beat(3, 0, 0, 0, 128, 0, 1'b1, lat);
    n_cmp++; if (u_y1_re !== 16'sd2) begin n_err++; $display("FAIL rnd_pos_r1 got %0d want 2", u_y1_re); end
    n_cmp++; if (r_y1_re !== 16'sd1) begin n_err++; $display("FAIL rnd_pos_r0 got %0d want 1", r_y1_re); end
    n_cmp++; if (r_y0_re !== 16'sd3) begin n_err++; $display("FAIL rnd_y0_exact got %0d want 3", r_y0_re); end
    drive_beat(-3, 0, 0, 0, 128, 0, 1'b1, lat);
    n_cmp++; if (u_y1_re !== -16'sd1) begin n_err++; $display("FAIL rnd_neg_r1 got %0d want -1", u_y1_re); end
    n_cmp++; if (r_y1_re !== -16'sd2) begin n_err++; $display("FAIL rnd_neg_r0 got %0d want -2", r_y1_re); end
  endtask

  task automatic test_saturation();
    int lat;
    drive_beat(32767, -32768, 32767, -32768, 256, 0, 1'b1, lat);
    n_cmp++; if (u_y0_re !== 16'sd32767 || u_y0_im !== -16'sd32768) begin n_err++; $display("FAIL sat_y0 got (%0d,%0d) want (32767,-32768)", u_y0_re, u_y0_im); end
    n_cmp++; if (u_y1_re !== 16'sd0 || u_y1_im !== 16'sd0) begin n_err++; $display("FAIL sat_y1 got (%0d,%0d) want (0,0)", u_y1_re, u_y1_im); end
    n_cmp++; if (u_sat !== 1'b1) begin n_err++; $display("FAIL sat_flag got %b want 1", u_sat); end
    n_cmp++; if (s_y0_re !== 16'sd32767 || s_y0_im !== -16'sd32768 || s_sat !== 1'b0) begin
      n_err++; $display("FAIL sat_scaled got (%0d,%0d) sat=%b want (32767,-32768) sat=0", s_y0_re, s_y0_im, s_sat); end
    @(posedge clk); #1;
    n_cmp++; if (u_sat_sticky !== 1'b1) begin n_err++; $display("FAIL sticky_set got %b want 1", u_sat_sticky); end
    n_cmp++; if (s_sat_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_scaled got %b want 0", s_sat_sticky); end
    n_cmp++; if (u_sat !== 1'b0) begin n_err++; $display("FAIL sat_bubble got %b want 0", u_sat); end
    @(negedge clk); sat_clr = 1'b1;
    @(posedge clk); #1; sat_clr = 1'b0;
    n_cmp++; if (u_sat_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_clr got %b want 0", u_sat_sticky); end

    // Stalled saturating beat: held outputs, then transfer together with clear.
    drive_beat(32767, -32768, 32767, -32768, 256, 0, 1'b0, lat);
    n_cmp++; if (u_out_valid !== 1'b1 || u_in_ready !== 1'b0) begin n_err++; $display("FAIL stall_state got valid=%b ready=%b want 1 0", u_out_valid, u_in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (u_out_valid !== 1'b1 || u_y0_re !== 16'sd32767 || u_sat !== 1'b1) begin
      n_err++; $display("FAIL stall_hold got valid=%b y0=%0d sat=%b want 1 32767 1", u_out_valid, u_y0_re, u_sat); end
    n_cmp++; if (u_sat_sticky !== 1'b0) begin n_err++; $display("FAIL stall_no_sticky got %b want 0", u_sat_sticky); end
    @(negedge clk); out_ready = 1'b1; sat_clr = 1'b1;
    @(posedge clk); #1; sat_clr = 1'b0;
    n_cmp++; if (u_sat_sticky !== 1'b0) begin n_err++; $display("FAIL sticky_clr_wins got %b want 0", u_sat_sticky); end
    n_cmp++; if (u_out_valid !== 1'b0) begin n_err++; $display("FAIL stall_release got valid=%b want 0", u_out_valid); end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic signed [15:0] prev_y0 = '0;
    b_re = '0; b_im = '0; a_im = '0; w_re = 16'sd256; w_im = '0;
    while (got < 8 && cyc < 400) begin
      @(negedge clk);
      if (stalled) begin
        n_cmp++; if (u_out_valid !== 1'b1 || u_y0_re !== prev_y0) begin
          n_err++; $display("FAIL bp_hold got valid=%b y0=%0d want 1 %0d", u_out_valid, u_y0_re, prev_y0); end
      end
      in_valid  = (sent < 8) ? 1'($urandom_range(0, 1)) : 1'b0;
      a_re      = 16'(sent + 1);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (u_out_valid && out_ready) begin
        n_cmp++; if (u_y0_re !== 16'(got + 1) || u_y1_re !== 16'(got + 1)) begin
          n_err++; $display("FAIL bp_order got y0=%0d y1=%0d want %0d", u_y0_re, u_y1_re, got + 1); end
        got++;
      end
      stalled = u_out_valid && !out_ready;
      prev_y0 = u_y0_re;
      if (in_valid && u_in_ready) sent++;
      cyc++;
    end
    n_cmp++; if (got !== 8) begin n_err++; $display("FAIL bp_count got %0d want 8", got); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if (u_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_extra got valid=%b want 0", u_out_valid); end
  endtask

  task automatic test_reset_mid();
    int lat;
    b_re = '0; b_im = '0; a_im = '0; w_re = 16'sd256; w_im = '0;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; a_re = 16'sd11;
    @(negedge clk); a_re = 16'sd12;
    @(negedge clk); a_re = 16'sd13;
    @(negedge clk); in_valid = 1'b0;
    n_cmp++; if (u_out_valid !== 1'b1 || u_y0_re !== 16'sd11) begin
      n_err++; $display("FAIL mid_pre got valid=%b y0=%0d want 1 11", u_out_valid, u_y0_re); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (u_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", u_out_valid); end
    n_cmp++; if (u_y0_re !== 16'sd0 || u_y1_re !== 16'sd0) begin n_err++; $display("FAIL mid_rst_data got %0d %0d want 0 0", u_y0_re, u_y1_re); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (u_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_flushed edge %0d got valid=%b want 0", i, u_out_valid); end
    end
    drive_beat(9, 0, 0, 0, 256, 0, 1'b1, lat);
    n_cmp++; if (lat !== 2 || u_y0_re !== 16'sd9 || u_y1_re !== 16'sd9) begin
      n_err++; $display("FAIL mid_new got lat=%0d y0=%0d y1=%0d want 2 9 9", lat, u_y0_re, u_y1_re); end
    @(posedge clk); #1;
    n_cmp++; if (u_out_valid !== 1'b0) begin n_err++; $display("FAIL mid_alone got valid=%b want 0", u_out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
